// File: rtl/petio_hub_pkg.sv
// Shared types and constants for the PET I/O-page hub and its interrupt controller.
package petio_hub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_WAIT
  } hub_state_e;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_VEC  = 2'd2;
  localparam logic [1:0] REG_CLR  = 2'd3;

  localparam logic [7:0] DOUT_RST = 8'hFF;
  localparam logic [2:0] VEC_RST  = 3'd0;

  // Lowest set index of a slot vector (up to four slots), 0 when empty.
  function automatic logic [2:0] lowest_set(input logic [3:0] v);
    logic found;
    lowest_set = VEC_RST;
    found      = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[i] && !found) begin
        lowest_set = 3'(i);
        found      = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/petio_irq_ctrl.sv
// Maskable, prioritised interrupt controller with hub-register read mux.
// PETIO_IRQ_LATCH_EN enables edge-latched PENDING bits cleared via the CLEAR register.
module petio_irq_ctrl
  import petio_hub_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           reg_wr,
  input  logic [1:0]     reg_off,
  input  logic [NCH-1:0] wdata,
  input  logic [NCH-1:0] ch_irq,
  output logic [7:0]     rdata,
  output logic           irq,
  output logic [2:0]     irq_vec
);

  logic [NCH-1:0] mask_q;
  logic [NCH-1:0] pend_live;
  logic [NCH-1:0] active;
  logic [3:0]     active_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '1;
    end else if (reg_wr && reg_off == REG_MASK) begin
      mask_q <= wdata;
    end
  end

`ifdef PETIO_IRQ_LATCH_EN
  logic [NCH-1:0] irq_prev;
  logic [NCH-1:0] pend_q;
  logic [NCH-1:0] clr_bits;

  assign clr_bits = (reg_wr && reg_off == REG_CLR) ? wdata : '0;

  // A fresh rising edge is OR-ed in after the clear, so a coincident set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev <= '0;
      pend_q   <= '0;
    end else begin
      irq_prev <= ch_irq;
      pend_q   <= (pend_q & ~clr_bits) | (ch_irq & ~irq_prev);
    end
  end

  assign pend_live = pend_q;
`else
  assign pend_live = ch_irq;
`endif

  assign active = pend_live & mask_q;

  always_comb begin
    active_ext            = '0;
    active_ext[NCH-1:0]   = active;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq     <= 1'b0;
      irq_vec <= VEC_RST;
    end else begin
      irq     <= |active;
      irq_vec <= lowest_set(active_ext);
    end
  end

  always_comb begin
    rdata = '1;
    case (reg_off)
      REG_MASK: begin
        rdata          = '1;
        rdata[NCH-1:0] = mask_q;
      end
      REG_PEND: begin
        rdata          = '0;
        rdata[NCH-1:0] = pend_live;
      end
      REG_VEC:  rdata = {irq, 4'b0000, irq_vec};
      default:  rdata = '1;
    endcase
  end

endmodule

// File: rtl/petio_bus_hub.sv
// PET 0xE8xx I/O-page hub: slot decode, strobes, wait states with RDY, registered read mux.
// Build with PETIO_IRQ_LATCH_EN defined to latch interrupt edges into PENDING.
module petio_bus_hub
  import petio_hub_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int WAIT_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  cs,
  input  logic                  we,
  input  logic [7:0]            addr,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  rdy,
  output logic [NCH-1:0]        ch_strobe,
  input  logic [NCH*8-1:0]      ch_data,
  input  logic [NCH*WAIT_W-1:0] ch_wait,
  input  logic [NCH-1:0]        ch_irq,
  output logic                  irq,
  output logic [2:0]            irq_vec
);

  hub_state_e        state;
  logic [NCH-1:0]    sel_now;
  logic [NCH-1:0]    sel_q;
  logic [WAIT_W-1:0] w_now;
  logic [WAIT_W-1:0] cnt_q;
  logic              we_q;
  logic              hub_q;
  logic [1:0]        off_q;
  logic [NCH-1:0]    wdata_q;
  logic              hub_sel;
  logic              reg_wr;
  logic              last_cycle;
  logic [7:0]        rd_and;
  logic [7:0]        reg_rdata;
  logic [7:0]        final_data;
  logic              unused_bits;

  assign unused_bits = ^{addr[3:2], data_in[7:NCH]};

  assign hub_sel = cs && (addr[7:4] == 4'h0);

  always_comb begin
    sel_now = '0;
    w_now   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      sel_now[i] = cs & addr[4+i];
      if (sel_now[i] && (ch_wait[i*WAIT_W +: WAIT_W] > w_now)) begin
        w_now = ch_wait[i*WAIT_W +: WAIT_W];
      end
    end
  end

  always_comb begin
    rd_and = 8'hFF;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sel_q[i]) begin
        rd_and = rd_and & ch_data[i*8 +: 8];
      end
    end
  end

  assign final_data = hub_q ? reg_rdata : rd_and;
  assign reg_wr     = (state == ST_STROBE) && hub_q && we_q;
  assign last_cycle = ((state == ST_STROBE) || (state == ST_WAIT)) && (cnt_q == '0);

  // cnt_q holds the remaining wait states; the STROBE cycle itself is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      hub_q     <= 1'b0;
      off_q     <= REG_MASK;
      wdata_q   <= '0;
      ch_strobe <= '0;
      rdy       <= 1'b1;
      data_out  <= DOUT_RST;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ce && cs) begin
            state     <= ST_STROBE;
            sel_q     <= sel_now;
            cnt_q     <= w_now;
            we_q      <= we;
            hub_q     <= hub_sel;
            off_q     <= addr[1:0];
            wdata_q   <= data_in[NCH-1:0];
            ch_strobe <= sel_now;
            rdy       <= 1'b0;
          end
        end
        ST_STROBE: begin
          ch_strobe <= '0;
          if (cnt_q != '0) begin
            state <= ST_WAIT;
            cnt_q <= cnt_q - WAIT_W'(1);
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - WAIT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (last_cycle) begin
        state <= ST_IDLE;
        rdy   <= 1'b1;
        if (!we_q) begin
          data_out <= final_data;
        end
      end
    end
  end

  petio_irq_ctrl #(
    .NCH(NCH)
  ) u_irq_ctrl (
    .clk     (clk),
    .reset   (reset),
    .reg_wr  (reg_wr),
    .reg_off (off_q),
    .wdata   (wdata_q),
    .ch_irq  (ch_irq),
    .rdata   (reg_rdata),
    .irq     (irq),
    .irq_vec (irq_vec)
  );

endmodule

// File: tb/tb_petio_bus_hub.sv
// Randomised self-checking bench for petio_bus_hub against a transaction-level model.
module tb_petio_bus_hub;

  localparam int NCH    = 4;
  localparam int WAIT_W = 2;
`ifdef PETIO_IRQ_LATCH_EN
  localparam bit LATCH   = 1'b1;
  localparam int IRQ_LAT = 2;
`else
  localparam bit LATCH   = 1'b0;
  localparam int IRQ_LAT = 1;
`endif

  logic                  clk;
  logic                  reset;
  logic                  ce;
  logic                  cs;
  logic                  we;
  logic [7:0]            addr;
  logic [7:0]            data_in;
  logic [7:0]            data_out;
  logic                  rdy;
  logic [NCH-1:0]        ch_strobe;
  logic [NCH*8-1:0]      ch_data;
  logic [NCH*WAIT_W-1:0] ch_wait;
  logic [NCH-1:0]        ch_irq;
  logic                  irq;
  logic [2:0]            irq_vec;

  petio_bus_hub #(
    .NCH    (NCH),
    .WAIT_W (WAIT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .cs        (cs),
    .we        (we),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .rdy       (rdy),
    .ch_strobe (ch_strobe),
    .ch_data   (ch_data),
    .ch_wait   (ch_wait),
    .ch_irq    (ch_irq),
    .irq       (irq),
    .irq_vec   (irq_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NCH-1:0] mask_m;
  logic [NCH-1:0] pend_m;
  logic [7:0]     dout_m;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NCH-1:0] pend_view();
    return LATCH ? pend_m : ch_irq;
  endfunction

  function automatic logic [2:0] vec_of(input logic [NCH-1:0] act);
    for (int i = 0; i < NCH; i++) begin
      if (act[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  function automatic logic irq_exp();
    return |(pend_view() & mask_m);
  endfunction

  task automatic check_irq(input string tag);
    check({tag, "_irq"}, {7'b0, irq}, {7'b0, irq_exp()});
    check({tag, "_vec"}, {5'b0, irq_vec}, {5'b0, vec_of(pend_view() & mask_m)});
  endtask

  task automatic set_irq(input logic [NCH-1:0] v);
    @(negedge clk);
    if (LATCH) pend_m = pend_m | (v & ~ch_irq);
    ch_irq = v;
    repeat (IRQ_LAT) @(posedge clk);
    #1;
    check_irq("set_irq");
  endtask

  // One CPU access; raise_mid ORs extra ch_irq bits in during the strobe cycle.
  task automatic access(input logic [7:0] a, input logic w_e, input logic [7:0] d,
                        input logic busy_ce, input logic [NCH-1:0] raise_mid);
    logic [NCH-1:0] sel;
    logic [NCH-1:0] old_irq;
    logic [NCH-1:0] rise;
    logic [7:0]     rd;
    int             w;
    logic           hub;
    hub = (a[7:4] == 4'h0);
    sel = '0;
    w   = 0;
    rd  = 8'hFF;
    for (int i = 0; i < NCH; i++) begin
      sel[i] = a[4+i];
      if (sel[i]) begin
        if (int'(ch_wait[i*WAIT_W +: WAIT_W]) > w) w = int'(ch_wait[i*WAIT_W +: WAIT_W]);
        rd = rd & ch_data[i*8 +: 8];
      end
    end
    if (hub) begin
      case (a[1:0])
        2'd0:    rd = 8'hF0 | 8'(mask_m);
        2'd1:    rd = 8'(pend_view());
        2'd2:    rd = {irq_exp(), 4'b0000, vec_of(pend_view() & mask_m)};
        default: rd = 8'hFF;
      endcase
    end
    old_irq = ch_irq;
    rise    = '0;

    @(negedge clk);
    ce = 1'b1; cs = 1'b1; addr = a; we = w_e; data_in = d;
    @(posedge clk);
    for (int k = 1; k <= 1 + w; k++) begin
      @(negedge clk);
      check("busy_rdy", {7'b0, rdy}, 8'h00);
      check("strobe", 8'(ch_strobe), (k == 1) ? 8'(sel) : 8'h00);
      ce = busy_ce;
      if (k == 1 && raise_mid != '0) begin
        rise   = raise_mid & ~old_irq;
        ch_irq = ch_irq | raise_mid;
      end
    end
    @(negedge clk);
    ce = 1'b0; cs = 1'b0;
    check("done_rdy", {7'b0, rdy}, 8'h01);
    check("done_strobe", 8'(ch_strobe), 8'h00);
    if (!w_e) dout_m = rd;
    check("data_out", data_out, dout_m);

    if (hub && w_e && a[1:0] == 2'd0) mask_m = d[NCH-1:0];
    if (LATCH) begin
      if (hub && w_e && a[1:0] == 2'd3) pend_m = pend_m & ~d[NCH-1:0];
      pend_m = pend_m | rise;
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    ch_data = '0; ch_wait = '0; ch_irq = '0;
    mask_m = '1; pend_m = '0; dout_m = 8'hFF;
    #1;
    check("rst_dout", data_out, 8'hFF);
    check("rst_rdy", {7'b0, rdy}, 8'h01);
    check("rst_strobe", 8'(ch_strobe), 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_irq("rst");

    // Single zero-wait slot read
    ch_data = {8'h11, 8'h22, 8'h33, 8'h5A};
    access(8'h10, 1'b0, 8'h00, 1'b0, '0);

    // Two slots selected: ANDed data, longest wait wins
    ch_data = {8'h00, 8'h00, 8'h3C, 8'hF0};
    ch_wait = {2'd0, 2'd0, 2'd2, 2'd1};
    access(8'h30, 1'b0, 8'h00, 1'b0, '0);

    // Reset during the WAIT phase of a w=3 access
    ch_wait = {2'd0, 2'd3, 2'd0, 2'd0};
    @(negedge clk);
    ce = 1'b1; cs = 1'b1; addr = 8'h40; we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ce = 1'b0; cs = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_rdy", {7'b0, rdy}, 8'h00);
    reset = 1'b1;
    #1;
    check("midrst_rdy", {7'b0, rdy}, 8'h01);
    check("midrst_strobe", 8'(ch_strobe), 8'h00);
    check("midrst_dout", data_out, 8'hFF);
    @(negedge clk);
    reset = 1'b0;
    mask_m = '1; pend_m = '0; dout_m = 8'hFF;
    ch_data = {8'h11, 8'hA5, 8'h33, 8'h44};
    access(8'h40, 1'b0, 8'h00, 1'b0, '0);

    // Mask and priority
    ch_wait = '0;
    access(8'h00, 1'b1, 8'h0B, 1'b0, '0);
    set_irq(4'b0110);
    access(8'h02, 1'b0, 8'h00, 1'b0, '0);
    access(8'h00, 1'b0, 8'h00, 1'b0, '0);

    // Empty selection while a ce pulse arrives during the access
    access(8'h08, 1'b0, 8'h00, 1'b1, '0);
    ch_wait = {2'd3, 2'd1, 2'd2, 2'd0};
    access(8'hC0, 1'b0, 8'h00, 1'b1, '0);

    if (LATCH) begin
      access(8'h00, 1'b1, 8'h0F, 1'b0, '0);
      set_irq(4'b0000);
      access(8'h03, 1'b1, 8'h0F, 1'b0, '0);
      set_irq(4'b0100);
      set_irq(4'b0000);
      access(8'h01, 1'b0, 8'h00, 1'b0, '0);
      access(8'h03, 1'b1, 8'h04, 1'b0, '0);
      @(posedge clk); #1;
      check_irq("after_clr");
      access(8'h03, 1'b1, 8'h04, 1'b0, 4'b0100);
      access(8'h01, 1'b0, 8'h00, 1'b0, '0);
      set_irq(4'b0000);
    end

    // Randomised traffic
    for (int n = 0; n < 120; n++) begin
      logic [7:0] a;
      ch_data = {$urandom(), $urandom()};
      ch_wait = NCH*WAIT_W'($urandom());
      if ($urandom_range(0, 2) == 0) set_irq(NCH'($urandom()));
      if ($urandom_range(0, 2) == 0) a = {4'h0, 4'($urandom())};
      else                           a = 8'($urandom());
      access(a, ($urandom_range(0, 3) == 0), 8'($urandom()), 1'($urandom()), '0);
    end
    @(posedge clk); #1;
    check_irq("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
